// File: rtl/mc_control_fsm.sv
// Multicycle sequencing controller for the RV32I core: walks each instruction
// through fetch/decode/execute/memory/writeback. Optional feature: MCFSM_PERF_EN.
module mc_control_fsm (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [6:0]  OP,
  input  logic        MEMRDY,
  output logic        ADRSRC,
  output logic        IRWRITE,
  output logic        PCUPDATE,
  output logic        BRANCH,
  output logic        REGWRITE,
  output logic        MEMWRITE,
  output logic [1:0]  RSLTSRC,
  output logic [1:0]  ALUSRCA,
  output logic [1:0]  ALUSRCB,
  output logic [1:0]  ALUOP,
  output logic [1:0]  IMMSRC,
  output logic        ILLEGAL
`ifdef MCFSM_PERF_EN
  ,
  output logic [31:0] INSTRET
`endif
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_illegal;

  // State register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Moore datapath controls; the memory handshake only
  // gates the IR/PC load in FETCH and the exits of the memory states.
  always_comb begin
    w_next_state = r_state;
    ADRSRC       = 1'b0;
    IRWRITE      = 1'b0;
    PCUPDATE     = 1'b0;
    BRANCH       = 1'b0;
    REGWRITE     = 1'b0;
    MEMWRITE     = 1'b0;
    RSLTSRC      = 2'b00;
    ALUSRCA      = 2'b00;
    ALUSRCB      = 2'b00;
    ALUOP        = 2'b00;
    case (r_state)
      S_FETCH: begin
        RSLTSRC  = 2'b10;
        ALUSRCB  = 2'b10;
        IRWRITE  = MEMRDY;
        PCUPDATE = MEMRDY;
        if (MEMRDY) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSRCA = 2'b01;
        ALUSRCB = 2'b01;
        case (OP)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECR;
          OP_I:         w_next_state = S_EXECI;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_JAL:       w_next_state = S_JAL;
          default:      w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSRCA      = 2'b10;
        ALUSRCB      = 2'b01;
        w_next_state = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ADRSRC = 1'b1;
        if (MEMRDY) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        RSLTSRC      = 2'b01;
        REGWRITE     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWR: begin
        ADRSRC   = 1'b1;
        MEMWRITE = 1'b1;
        if (MEMRDY) w_next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUSRCA      = 2'b10;
        ALUSRCB      = 2'b00;
        ALUOP        = 2'b10;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSRCA      = 2'b10;
        ALUSRCB      = 2'b01;
        ALUOP        = 2'b10;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RSLTSRC      = 2'b00;
        REGWRITE     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BEQ: begin
        ALUSRCA      = 2'b10;
        ALUSRCB      = 2'b00;
        ALUOP        = 2'b01;
        BRANCH       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSRCA      = 2'b01;
        ALUSRCB      = 2'b10;
        PCUPDATE     = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_TRAP: begin
        w_next_state = S_TRAP;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // Immediate extend type straight from the opcode
  always_comb begin
    IMMSRC = 2'b00;
    case (OP)
      OP_SW:   IMMSRC = 2'b01;
      OP_BEQ:  IMMSRC = 2'b10;
      OP_JAL:  IMMSRC = 2'b11;
      default: IMMSRC = 2'b00;
    endcase
  end

  // Sticky illegal-opcode flag, set on the edge that enters TRAP
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_illegal <= 1'b0;
    end else if (w_next_state == S_TRAP) begin
      r_illegal <= 1'b1;
    end
  end

  assign ILLEGAL = r_illegal;

`ifdef MCFSM_PERF_EN
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;

  // An instruction retires on the edge that returns the FSM to FETCH
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BEQ)   || ((r_state == S_MEMWR) && MEMRDY);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign INSTRET = r_instret;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed vector table, hand-written
// multicycle sequences, and a randomized run against a phase-list model.
module tb_mc_control_fsm;

  logic        CLK;
  logic        RSTN;
  logic [6:0]  OP;
  logic        MEMRDY;
  logic        ADRSRC, IRWRITE, PCUPDATE, BRANCH, REGWRITE, MEMWRITE;
  logic [1:0]  RSLTSRC, ALUSRCA, ALUSRCB, ALUOP, IMMSRC;
  logic        ILLEGAL;
`ifdef MCFSM_PERF_EN
  logic [31:0] INSTRET;
`endif

  mc_control_fsm dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .OP       (OP),
    .MEMRDY   (MEMRDY),
    .ADRSRC   (ADRSRC),
    .IRWRITE  (IRWRITE),
    .PCUPDATE (PCUPDATE),
    .BRANCH   (BRANCH),
    .REGWRITE (REGWRITE),
    .MEMWRITE (MEMWRITE),
    .RSLTSRC  (RSLTSRC),
    .ALUSRCA  (ALUSRCA),
    .ALUSRCB  (ALUSRCB),
    .ALUOP    (ALUOP),
    .IMMSRC   (IMMSRC),
    .ILLEGAL  (ILLEGAL)
`ifdef MCFSM_PERF_EN
    ,
    .INSTRET  (INSTRET)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [6:0] LW  = 7'h03;
  localparam logic [6:0] SW  = 7'h23;
  localparam logic [6:0] RT  = 7'h33;
  localparam logic [6:0] IT  = 7'h13;
  localparam logic [6:0] BQ  = 7'h63;
  localparam logic [6:0] JL  = 7'h6F;
  localparam logic [6:0] BAD = 7'h7F;

  // Instruction phases (bench-side names, not the DUT encoding)
  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MW = 5;
  localparam int PH_XR = 6, PH_XI = 7, PH_AWB = 8, PH_BEQ = 9, PH_JAL = 10, PH_TRAP = 11;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [14:0] mk(logic adr, logic ir, logic pc, logic br,
                                     logic rw, logic mw, logic [1:0] rs,
                                     logic [1:0] a, logic [1:0] b,
                                     logic [1:0] op, logic ill);
    return {adr, ir, pc, br, rw, mw, rs, a, b, op, ill};
  endfunction

  function automatic logic [14:0] act_out();
    return {ADRSRC, IRWRITE, PCUPDATE, BRANCH, REGWRITE, MEMWRITE,
            RSLTSRC, ALUSRCA, ALUSRCB, ALUOP, ILLEGAL};
  endfunction

  function automatic logic [14:0] exp_out(int p, logic mr);
    case (p)
      PH_F:    return mk(0, mr, mr, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
      PH_D:    return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
      PH_MA:   return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
      PH_MR:   return mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      PH_MWB:  return mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0);
      PH_MW:   return mk(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      PH_XR:   return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
      PH_XI:   return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
      PH_AWB:  return mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      PH_BEQ:  return mk(0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
      PH_JAL:  return mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
      PH_TRAP: return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(logic [6:0] op);
    case (op)
      SW:      return 2'b01;
      BQ:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, settle, then the caller samples
  task automatic cyc(input logic [6:0] op, input logic mr);
    @(negedge CLK);
    RSTN   = 1'b1;
    OP     = op;
    MEMRDY = mr;
    #1;
  endtask

  // Asynchronous reset asserted in the low phase, away from any rising edge
  task automatic do_reset();
    RSTN = 1'b0;
    #1;
  endtask

  // Phase-list model: each instruction is a fixed sequence of phases, with
  // FETCH/MEMRD/MEMWR repeating while memory is not ready.
  int         ph[5];
  int         ph_len;
  int         ph_idx;
  logic [6:0] cur_op;
  int         retired;

  function automatic void load_instr(logic [6:0] op);
    cur_op = op;
    ph_idx = 0;
    ph[0]  = PH_F;
    ph[1]  = PH_D;
    case (op)
      LW: begin ph[2] = PH_MA; ph[3] = PH_MR; ph[4] = PH_MWB; ph_len = 5; end
      SW: begin ph[2] = PH_MA; ph[3] = PH_MW; ph_len = 4; end
      RT: begin ph[2] = PH_XR; ph[3] = PH_AWB; ph_len = 4; end
      IT: begin ph[2] = PH_XI; ph[3] = PH_AWB; ph_len = 4; end
      BQ: begin ph[2] = PH_BEQ; ph_len = 3; end
      JL: begin ph[2] = PH_JAL; ph[3] = PH_AWB; ph_len = 4; end
      default: begin ph[2] = PH_TRAP; ph_len = 3; end
    endcase
  endfunction

  function automatic logic [6:0] pick_op();
    int r;
    logic [6:0] v;
    r = $urandom_range(0, 15);
    case (r % 6)
      0: v = LW;
      1: v = SW;
      2: v = RT;
      3: v = IT;
      4: v = BQ;
      default: v = JL;
    endcase
    if (r >= 14) v = 7'($urandom);
    return v;
  endfunction

  initial begin
    int n_mw, n_rw, bad, trap_cyc;
    logic mr;
    logic [14:0] fv;

    RSTN   = 1'b0;
    OP     = LW;
    MEMRDY = 1'b1;

    tbl[0]  = '{LW, 1'b1, exp_out(PH_F, 1'b1)};
    tbl[1]  = '{LW, 1'b1, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0)};
    tbl[2]  = '{LW, 1'b1, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0)};
    tbl[3]  = '{LW, 1'b1, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0)};
    tbl[4]  = '{LW, 1'b1, mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0)};
    tbl[5]  = '{BQ, 1'b1, mk(0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0)};
    tbl[6]  = '{BQ, 1'b1, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0)};
    tbl[7]  = '{BQ, 1'b1, mk(0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0)};
    tbl[8]  = '{SW, 1'b0, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0)};
    tbl[9]  = '{SW, 1'b1, mk(0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0)};
    tbl[10] = '{SW, 1'b1, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0)};
    tbl[11] = '{SW, 1'b1, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0)};
    tbl[12] = '{SW, 1'b0, mk(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0)};
    tbl[13] = '{SW, 1'b1, mk(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0)};
    tbl[14] = '{JL, 1'b1, mk(0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0)};

    // Reset state: FETCH controls, IR/PC load following MEMRDY
    #2;
    chk("reset_outs_rdy1", 32'(act_out()), 32'(mk(0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0)));
    MEMRDY = 1'b0;
    #1;
    chk("reset_outs_rdy0", 32'(act_out()), 32'(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0)));
`ifdef MCFSM_PERF_EN
    chk("reset_instret", INSTRET, 32'd0);
`endif

    // Directed vector table: LW, BEQ, SW with stalls
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].op, tbl[i].mr);
      chk($sformatf("tbl_%0d", i), 32'(act_out()), 32'(tbl[i].exp));
    end

    // SW with three not-ready cycles in MEMWR: 7 cycles, MEMWRITE for 4
    do_reset();
    n_mw = 0;
    n_rw = 0;
    for (int k = 0; k < 7; k++) begin
      cyc(SW, (k < 3 || k == 6) ? 1'b1 : 1'b0);
      n_mw += int'(MEMWRITE);
      n_rw += int'(REGWRITE);
    end
    chk("sw_memwrite_cycles", 32'(n_mw), 32'd4);
    chk("sw_regwrite_cycles", 32'(n_rw), 32'd0);
    cyc(RT, 1'b1);
    chk("sw_back_to_fetch", 32'({IRWRITE, PCUPDATE, RSLTSRC}), 32'({1'b1, 1'b1, 2'b10}));

    // Five not-ready cycles in FETCH, then a single load pulse and DECODE
    do_reset();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(RT, 1'b0);
      bad += int'(IRWRITE | PCUPDATE);
    end
    chk("fetch_stall_enables", 32'(bad), 32'd0);
    cyc(RT, 1'b1);
    chk("fetch_load_pulse", 32'({IRWRITE, PCUPDATE}), 32'(2'b11));
    cyc(RT, 1'b1);
    chk("fetch_then_decode", 32'({IRWRITE, PCUPDATE, ALUSRCA, ALUSRCB}), 32'({2'b00, 2'b01, 2'b01}));

    // Illegal opcode: TRAP holds ILLEGAL with every control low
    do_reset();
    cyc(BAD, 1'b1);
    cyc(BAD, 1'b1);
    chk("trap_decode_illegal_low", 32'(ILLEGAL), 32'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(7'($urandom), 1'($urandom));
      if (act_out() !== exp_out(PH_TRAP, 1'b0)) bad++;
    end
    chk("trap_hold_20", 32'(bad), 32'd0);
    MEMRDY = 1'b1;
    do_reset();
    chk("trap_reset_outs", 32'(act_out()), 32'(exp_out(PH_F, 1'b1)));

    // Ten R-types, then a reset asserted while a load waits in MEMRD
    for (int k = 0; k < 40; k++) cyc(RT, 1'b1);
    cyc(LW, 1'b1);
`ifdef MCFSM_PERF_EN
    chk("instret_10", INSTRET, 32'd10);
`endif
    cyc(LW, 1'b1);
    cyc(LW, 1'b1);
    cyc(LW, 1'b0);
    chk("memrd_wait", 32'(act_out()), 32'(exp_out(PH_MR, 1'b0)));
    do_reset();
    chk("memrd_async_reset", 32'(act_out()), 32'(exp_out(PH_F, 1'b0)));
`ifdef MCFSM_PERF_EN
    chk("memrd_reset_instret", INSTRET, 32'd0);
`endif

    // Randomized run against the phase-list model
    retired  = 0;
    trap_cyc = 0;
    load_instr(pick_op());
    for (int c = 0; c < 3000; c++) begin
      mr = ($urandom_range(0, 3) != 0);
      cyc((ph[ph_idx] == PH_F) ? 7'($urandom) : cur_op, mr);
      fv = exp_out(ph[ph_idx], mr);
      chk("rand_outs", 32'(act_out()), 32'(fv));
      chk("rand_immsrc", 32'(IMMSRC), 32'(exp_imm(OP)));
`ifdef MCFSM_PERF_EN
      chk("rand_instret", INSTRET, 32'(retired));
`endif
      if (ph[ph_idx] == PH_TRAP) begin
        trap_cyc++;
        if (trap_cyc > 4) begin
          do_reset();
          trap_cyc = 0;
          retired  = 0;
          load_instr(pick_op());
        end
      end else if ($urandom_range(0, 199) == 0) begin
        do_reset();
        retired = 0;
        load_instr(pick_op());
      end else if (!((ph[ph_idx] == PH_F || ph[ph_idx] == PH_MR ||
                      ph[ph_idx] == PH_MW) && !mr)) begin
        ph_idx++;
        if (ph_idx == ph_len) begin
          retired++;
          load_instr(pick_op());
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle sequencing controller for the RV32I core. It replaces the single-cycle main decoder when the core shares one memory port and one ALU across instruction phases. It walks each instruction through fetch, decode, execute, memory and writeback states, and drives Moore-style select and enable signals into the shared datapath. A MEMRDY handshake stretches the memory phases.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock
- RSTN  in  1  reset; asynchronous, active-low (already decided)
- OP  in  7  opcode of the instruction register (IR[6:0]); sampled in DECODE
- MEMRDY  in  1  memory access completes this cycle
- ADRSRC  out  1  memory address select: 0 = PC, 1 = ALU result register
- IRWRITE  out  1  instruction register (and OLDPC) load enable
- PCUPDATE  out  1  unconditional PC load enable
- BRANCH  out  1  conditional PC load; ANDed with ZERO outside this block
- REGWRITE  out  1  register file write enable
- MEMWRITE  out  1  data memory write strobe
- RSLTSRC  out  2  result mux select: 00 = ALUOUT, 01 = DATA, 10 = ALU result
- ALUSRCA  out  2  ALU input A select: 00 = PC, 01 = OLDPC, 10 = RS1 register
- ALUSRCB  out  2  ALU input B select: 00 = RS2 register, 01 = IMMEXT, 10 = constant 4
- ALUOP  out  2  to the ALU decoder: 00 = add, 01 = sub/compare, 10 = funct-decoded
- IMMSRC  out  2  extend type from OP, combinational: LW/ITY 00, SW 01, BEQ 10, JAL 11, others 00
- ILLEGAL  out  1  sticky flag: an unsupported opcode was decoded
- INSTRET  out  32  retired-instruction count; present only with MCFSM_PERF_EN

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP. State is encoded in 4 bits.
- All outputs except IMMSRC are functions of state only. Any output not listed for a state is 0.
- FETCH: ADRSRC=0, ALUSRCA=00, ALUSRCB=10, ALUOP=00, RSLTSRC=10.
  - IRWRITE and PCUPDATE are asserted only when MEMRDY=1.
  - Moves to DECODE when MEMRDY=1; otherwise stays in FETCH.
- DECODE: ALUSRCA=01, ALUSRCB=01, ALUOP=00 (branch/jump target computation). Next state by OP:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → TRAP
- MEMADR: ALUSRCA=10, ALUSRCB=01, ALUOP=00. Next state is MEMRD if OP=LW, else MEMWR.
- MEMRD: ADRSRC=1. Waits for MEMRDY=1, then → MEMWB.
- MEMWB: RSLTSRC=01, REGWRITE=1. → FETCH.
- MEMWR: ADRSRC=1, MEMWRITE=1.
  - MEMWRITE stays high while waiting.
  - Exits to FETCH on the cycle MEMRDY=1.
- EXECR: ALUSRCA=10, ALUSRCB=00, ALUOP=10. → ALUWB.
- EXECI: ALUSRCA=10, ALUSRCB=01, ALUOP=10. → ALUWB.
- ALUWB: RSLTSRC=00, REGWRITE=1. → FETCH.
- BEQ: ALUSRCA=10, ALUSRCB=00, ALUOP=01, RSLTSRC=00, BRANCH=1. → FETCH.
- JAL: ALUSRCA=01, ALUSRCB=10, ALUOP=00, RSLTSRC=00, PCUPDATE=1. → ALUWB.
- TRAP: ILLEGAL=1 and all enables 0. TRAP is terminal; only RSTN leaves it.
- ILLEGAL is registered: it is set on entry to TRAP and cleared only by reset.

## Timing
- Reset (RSTN=0, asynchronous): state=FETCH, ILLEGAL=0, INSTRET=0.
  - Outputs immediately take the FETCH values above.
  - IRWRITE and PCUPDATE follow MEMRDY.
- A reset mid-instruction abandons the instruction. No write enable may glitch high on reset assertion.
- Cycles per instruction with MEMRDY held at 1:
  - LW 5
  - SW 4
  - R-type 4
  - I-type 4
  - BEQ 3
  - JAL 4
- Each cycle with MEMRDY=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MEMRDY is ignored in every other state.
- OP is used only in DECODE and MEMADR. The IR must not change outside FETCH, which is guaranteed because IRWRITE is gated.

## Configuration
- MCFSM_PERF_EN defined: the INSTRET port and a 32-bit counter exist.
  - The counter increments on every transition into FETCH from MEMWB, ALUWB, BEQ, or MEMWR (with MEMRDY=1).
  - It wraps from 0xFFFFFFFF to 0.
  - It does not count in TRAP.
- MCFSM_PERF_EN undefined: no INSTRET port and no counter logic. All other behaviour is identical.

## Test plan
- Reset, then MEMRDY=1 and OP=0000011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. REGWRITE=1 and RSLTSRC=01 in cycle 5; back to FETCH in cycle 6.
- OP=0100011 with MEMRDY=0 for 3 cycles in MEMWR → MEMWRITE high for 4 cycles, then FETCH. Total 7 cycles; REGWRITE stays 0 throughout.
- OP=0110011, then 0010011, then 1100011, then 1101111 back-to-back with MEMRDY=1 → 4, 4, 3 and 4 cycles. BEQ cycle shows BRANCH=1 and ALUOP=01; JAL shows PCUPDATE=1, then ALUWB.
- MEMRDY=0 for 5 cycles in FETCH → IRWRITE=0 and PCUPDATE=0 throughout. Both pulse for one cycle when MEMRDY=1; DECODE follows.
- OP=1111111 → TRAP after DECODE and ILLEGAL=1 persists for 20 cycles with all enables 0. RSTN pulse → FETCH, ILLEGAL=0.
- With MCFSM_PERF_EN: 10 instructions retired → INSTRET=10. RSTN asserted in MEMRD → INSTRET=0, state=FETCH asynchronously.
